// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op encodings,
// default latencies and the control state type.
package muldiv_unit_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned XLEN = 32;

  localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at Start, held pending, and committed after the busy countdown.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic            WriteHiLo,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            ReadSel,
  output logic            Busy,
  output logic [XLEN-1:0] RD
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   phi_q, phi_d, plo_q, plo_d;
  logic              dz_q, dz_d;

  logic              is_signed, is_div, start_ok, mt_ok;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign is_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign is_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign start_ok  = Start && (state_q == ST_IDLE) &&
                     ((Op == OP_MULT) || (Op == OP_MULTU) || is_div);
  assign mt_ok     = WriteHiLo && !Start && (state_q == ST_IDLE) &&
                     ((Op == OP_MTHI) || (Op == OP_MTLO));

  // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU
  assign a_ext = is_signed ? {{XLEN{A[XLEN-1]}}, A} : {{XLEN{1'b0}}, A};
  assign b_ext = is_signed ? {{XLEN{B[XLEN-1]}}, B} : {{XLEN{1'b0}}, B};
  assign prod  = a_ext * b_ext;

  // Magnitude divide then restore signs; 0x80000000/-1 falls out as LO=0x80000000, HI=0
  assign a_neg = is_signed && A[XLEN-1];
  assign b_neg = is_signed && B[XLEN-1];
  assign a_mag = a_neg ? XLEN'(-A) : A;
  assign b_mag = (B == '0) ? XLEN'(1) : (b_neg ? XLEN'(-B) : B);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? XLEN'(-q_mag) : q_mag;
  assign rem   = a_neg ? XLEN'(-r_mag) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    dz_d    = dz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          phi_d   = is_div ? rem  : prod[2*XLEN-1:XLEN];
          plo_d   = is_div ? quot : prod[XLEN-1:0];
          dz_d    = is_div && (B == '0);
        end else if (mt_ok) begin
          if (Op == OP_MTHI) hi_d = A;
          else               lo_d = A;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!dz_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign RD   = ReadSel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed and random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start, WriteHiLo, ReadSel;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] RD;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .WriteHiLo(WriteHiLo),
    .A(A), .B(B), .ReadSel(ReadSel), .Busy(Busy), .RD(RD)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic [31:0] exp_rd[$];
  int          exp_busy[$];
  logic        rd_chk = 1'b0;
  int          busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: busy-window length, read-back values and protocol violations
  always @(negedge Clk) begin
    if (!Reset) begin
      busy_run = 0;
    end else begin
      if (Busy && (Start || WriteHiLo)) check("protocol_start_while_busy", 32'd1, 32'd0);
      if (Busy) busy_run++;
      else if (busy_run > 0) begin
        if (exp_busy.size() == 0) check("unexpected_busy", 32'(busy_run), 32'd0);
        else check("busy_len", 32'(busy_run), 32'(exp_busy.pop_front()));
        busy_run = 0;
      end
      if (rd_chk) begin
        if (exp_rd.size() == 0) check("rd_no_expect", RD, 32'hxxxxxxxx);
        else check(ReadSel ? "rd_hi" : "rd_lo", RD, exp_rd.pop_front());
      end
    end
  end

  // Reference model: plain 64-bit arithmetic on committed HI/LO
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; hi_m = up[63:32]; lo_m = up[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      3'd3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input logic sel);
    ReadSel = sel;
    rd_chk  = 1'b1;
    exp_rd.push_back(sel ? hi_m : lo_m);
    tick();
    rd_chk = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 40) begin
      tick();
      n++;
    end
    if (Busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    WriteHiLo = 1'b1; Op = op; A = a;
    tick();
    WriteHiLo = 1'b0;
    if (op == 3'd4) hi_m = a; else lo_m = a;
    check("mt_busy", 32'(Busy), 32'd0);
    rd(op == 3'd4);
  endtask

  task automatic muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic with_mt);
    Start = 1'b1; WriteHiLo = with_mt; Op = op; A = a; B = b;
    tick();
    Start = 1'b0; WriteHiLo = 1'b0;
    exp_busy.push_back((op == 3'd2 || op == 3'd3) ? DC : MC);
    wait_idle();
    model_op(op, a, b);
    rd(1'b0);
    rd(1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] rop;
    Reset = 1'b0; Start = 1'b0; WriteHiLo = 1'b0; ReadSel = 1'b0;
    Op = '0; A = '0; B = '0;
    tick();
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_rd_lo", RD, 32'd0);
    ReadSel = 1'b1; #1;
    check("reset_rd_hi", RD, 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    // Reset mid-run discards the pending op and clears HI/LO
    mt(3'd5, 32'hAAAA);
    mt(3'd4, 32'hBBBB);
    ReadSel = 1'b0;
    Start = 1'b1; Op = 3'd0; A = 32'd9; B = 32'd9;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Reset = 1'b0; #1;
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_rd", RD, 32'd0);
    hi_m = '0; lo_m = '0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    rd(1'b0);
    rd(1'b1);

    muldiv(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    muldiv(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    muldiv(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    muldiv(3'd3, 32'd7, 32'd2, 1'b0);
    mt(3'd4, 32'h1234);
    mt(3'd5, 32'h5678);
    muldiv(3'd2, 32'd77, 32'd0, 1'b0);
    muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    mt(3'd4, 32'hDEADBEEF);
    // Start and WriteHiLo together: the mul/div wins and the MT write is dropped
    muldiv(3'd0, 32'd4, 32'd5, 1'b1);

    // Start with an unused op does nothing
    Start = 1'b1; Op = 3'd6; A = 32'h55; B = 32'h66;
    tick();
    Start = 1'b0;
    check("bad_op_busy", 32'(Busy), 32'd0);
    rd(1'b0);
    rd(1'b1);

    // RD keeps showing committed LO during the run
    mt(3'd5, 32'd5);
    Start = 1'b1; Op = 3'd0; A = 32'd2; B = 32'd3;
    tick();
    Start = 1'b0;
    exp_busy.push_back(MC);
    for (int i = 0; i < int'(MC); i++) rd(1'b0);
    model_op(3'd0, 32'd2, 32'd3);
    rd(1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      if (rop < 3'd4) muldiv(rop, pick(), pick(), 1'b0);
      else            mt(rop, pick());
    end

    tick();
    tick();
    check("busy_queue_empty", 32'(exp_busy.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
